// File: rtl/clk_div_gen.sv
// clk_div_gen: multi-channel programmable clock divider.
// Each channel takes new settings over the config port and changes them only at a period boundary, so its output never glitches.
module clk_div_gen #(
    parameter int CHANNELS = 4,
    parameter int DIV_W = 8,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic [DIV_W-1:0]    cfg_high,
    input  logic                cfg_en,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);
    logic [CHANNELS-1:0] run, pend, pend_en, sel, n_run, n_pend;
    logic [DIV_W-1:0] cnt [CHANNELS], div [CHANNELS], hi [CHANNELS];
    logic [DIV_W-1:0] pdiv [CHANNELS], phi [CHANNELS];
    logic [DIV_W-1:0] n_cnt [CHANNELS], n_div [CHANNELS], n_hi [CHANNELS];
    logic accept, illegal, wr;
    logic [DIV_W-1:0] hi_c;

    // A channel number that is out of range matches no channel, so it leaves ready high.
    always_comb begin
        sel = '0;
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CW'(i)) begin
                sel[i] = 1'b1;
                cfg_ready = ~pend[i];
            end
        end
    end

    assign accept = cfg_valid & cfg_ready;
    assign illegal = ~|sel | (cfg_en & ~|cfg_div);
    assign wr = accept & ~illegal;
    assign hi_c = ~|cfg_high ? DIV_W'(1) : (cfg_high > cfg_div ? cfg_div : cfg_high);

    // Compute next state first so that clk_out and tick can be registered straight from it.
    always_comb begin
        n_run = run;
        n_pend = pend;
        n_cnt = cnt;
        n_div = div;
        n_hi = hi;
        for (int i = 0; i < CHANNELS; i++) begin
            if (run[i]) begin
                n_cnt[i] = cnt[i] == div[i] ? '0 : cnt[i] + 1'b1;
                if (cnt[i] == div[i] && pend[i]) begin
                    n_div[i] = pdiv[i];
                    n_hi[i] = phi[i];
                    n_pend[i] = 1'b0;
                    n_run[i] = pend_en[i];
                end
                if (wr && sel[i]) n_pend[i] = 1'b1;
            end else if (wr && sel[i]) begin
                n_div[i] = cfg_div;
                n_hi[i] = hi_c;
                n_run[i] = cfg_en;
                n_cnt[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run <= '0;
            pend <= '0;
            pend_en <= '0;
            clk_out <= '0;
            tick <= '0;
            cfg_err <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
                div[i] <= DIV_W'(1);
                hi[i] <= DIV_W'(1);
                pdiv[i] <= '0;
                phi[i] <= '0;
            end
        end else begin
            run <= n_run;
            pend <= n_pend;
            cfg_err <= accept & illegal;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= n_cnt[i];
                div[i] <= n_div[i];
                hi[i] <= n_hi[i];
                clk_out[i] <= n_run[i] & (n_cnt[i] < n_hi[i]);
                tick[i] <= n_run[i] & ~|n_cnt[i];
                if (wr && sel[i] && run[i]) begin
                    pdiv[i] <= cfg_div;
                    phi[i] <= hi_c;
                    pend_en[i] <= cfg_en;
                end
            end
        end
    end
endmodule
